// File: rtl/param_data_mem.sv
// Single-port data memory: valid/ready requests, byte-lane strobes, RD_LAT-stage read pipeline
// (Resp_Valid is sampled high at the RD_LAT-th edge after the accept edge), clear sweep after reset.
// Optional macro DMEM_PRELOAD_EN: skip the sweep, keep contents across Rst.
module param_data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic                  Req_Write,
  input  logic [ADDR_W-1:0]     Req_Addr,
  input  logic [DATA_W-1:0]     Req_WData,
  input  logic [DATA_W/8-1:0]   Req_BE,
  output logic                  Resp_Valid,
  output logic [DATA_W-1:0]     Resp_RData,
  output logic                  Busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_C  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [RD_LAT-1:0]   vld_p_q;
  logic [DATA_W-1:0]   rdata_p_q [RD_LAT];

  logic                in_range;
  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic                clr_en;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   rd_word;

`ifdef DMEM_PRELOAD_EN
  localparam state_e RST_STATE = S_RUN;
  assign clr_en = 1'b0;
`else
  localparam state_e RST_STATE = S_CLEAR;
  assign clr_en = (state_q == S_CLEAR) && !Rst;
`endif

  // Rst overrides the handshake/status outputs combinationally so they are clean from the first reset cycle
  assign Req_Ready = !Rst && (state_q == S_RUN);
  assign Busy      = Rst || (state_q == S_CLEAR);

  assign in_range = {1'b0, Req_Addr} < DEPTH_C;
  assign idx      = Req_Addr[IDX_W-1:0];
  assign accept   = Req_Valid && Req_Ready;
  assign wr_en    = accept && Req_Write && in_range;
  assign rd_en    = accept && !Req_Write;
  assign rd_word  = in_range ? mem_q[idx] : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (Req_BE[i]) mem_q[idx][8*i +: 8] <= Req_WData[8*i +: 8];
      end
    end
  end

  // Stage p0: word sampled from the array at the accept edge; later stages only shift
  always_ff @(posedge Clk) begin
    if (rd_en) rdata_p_q[0] <= rd_word;
    for (int i = 1; i < RD_LAT; i++) rdata_p_q[i] <= rdata_p_q[i-1];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p_q <= '0;
    end else begin
      vld_p_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_p_q[i] <= vld_p_q[i-1];
    end
  end

  // Stage RD_LAT-1: response output, data forced to zero outside the valid pulse
  assign Resp_Valid = vld_p_q[RD_LAT-1] && !Rst;
  assign Resp_RData = Resp_Valid ? rdata_p_q[RD_LAT-1] : '0;

endmodule
